instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache between the fetch stage and the backing instruction memory. The fetch stage presents `pcF` every cycle. On a hit the cache returns the instruction combinationally in the same cycle. On a miss it raises `stallC`, which the fetch stage ORs into its stall. It then refills the whole line over a valid/ready request plus burst-response memory port, and resumes. A `flush` input invalidates all lines; it serves as the fence.i hook.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction and memory word width.
- ADDR_WIDTH, 32, byte address width.
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (low = reset).
- pcF  in  ADDR_WIDTH  fetch byte address. Bits [1:0] are ignored.
- reqF  in  1  fetch request valid. When low, there is no lookup, no miss and `stallC` stays 0.
- instrF  out  DATA_WIDTH  instruction on a hit, otherwise 32'h00000013 (NOP).
- stallC  out  1  high whenever `reqF` is high and the current lookup is not a hit.
- flush  in  1  single-cycle pulse that invalidates every line.
- mem_req_valid  out  1  refill request valid.
- mem_req_addr  out  ADDR_WIDTH  line-aligned byte address of the refill.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  one response beat is valid.
- mem_resp_data  in  DATA_WIDTH  response word. Beats arrive in ascending word order.

## Operation
- Address split: word offset = pcF[2+WO-1:2], with WO = log2(WORDS_PER_LINE). Index = the next log2(LINES) bits. Tag = the remaining upper bits. Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: data array of LINES×WORDS_PER_LINE words, tag array, and one valid bit per line. Only the valid bits are reset.
- Hit condition: state is IDLE, reqF is high, valid[index] is set, and tag[index] equals the tag of pcF.

State machine:
- IDLE
  - Hit: instrF = data[index][offset] and stallC = 0.
  - Miss with reqF high: latch the line address (pcF with offset and byte bits cleared) and go to REQ.
  - flush high: clear all valid bits. Flush takes priority over starting a refill, so a flush and a miss in the same cycle stay in IDLE.
- REQ
  - mem_req_valid = 1 and mem_req_addr = latched address, both held stable until mem_req_ready.
  - On the handshake, clear the beat counter and go to WAIT.
- WAIT
  - Each mem_resp_valid writes mem_resp_data into data[latched index][beat] and increments the beat counter.
  - On the last beat (counter = WORDS_PER_LINE−1): write the tag, set valid, and return to IDLE.
- stallC is 1 throughout REQ and WAIT, and instrF is the NOP.
- Flush during REQ or WAIT: set `flush_pending`. At refill completion, clear all valid bits, including the line just filled, and clear `flush_pending`. The refill itself is never aborted, because the memory port has no cancel.
- Response beats outside WAIT are ignored. Memory must not return beats in the handshake cycle.
- pcF changes during REQ or WAIT do not affect the refill. After returning to IDLE, the current pcF is looked up afresh.

## Timing
- Reset, while rst is low at a clock edge:
  - state becomes IDLE, all valid bits 0, beat counter 0, flush_pending 0.
  - mem_req_valid = 0, mem_req_addr = 0.
  - Because all lines are invalid, the first request after reset misses.
- Reset during REQ or WAIT abandons the refill at once. The line is not marked valid, and any late beats are ignored in IDLE.
- Hit latency: 0 cycles (combinational from pcF to instrF and stallC).
- Miss cycle accounting:
  - 1 cycle of IDLE miss detection, with stallC already high.
  - REQ lasts at least 1 cycle.
  - WAIT lasts WORDS_PER_LINE beats plus any response gaps.
  - 1 IDLE cycle in which the hit is delivered.
  - Minimum miss penalty with default parameters: 6 stalled cycles, so the hit arrives in the 7th cycle after the miss is seen.
- The valid/tag write on the last beat becomes visible in the following IDLE cycle.
- The flush clear takes effect at the edge of the pulse. A lookup in the same cycle as the flush still uses the old valid bits.

## Test plan
- Cold miss: after reset, pcF=0x100 with reqF=1; memory ready immediately and beats 0xA0..0xA3 back to back. Expect stallC=1 for 6 cycles, mem_req_addr=0x100, then instrF=0xA0 with stallC=0.
- Same-line hits: after the cold miss, pcF=0x104, 0x108, 0x10C in consecutive cycles. Expect instrF=0xA1, 0xA2, 0xA3 with stallC=0 and no memory request.
- Conflict eviction: pcF=0x200 (index 0, tag 0x2) triggers a refill with 0xB0..0xB3. Then pcF=0x100 misses again, with mem_req_addr=0x100.
- Backpressure and gaps: mem_req_ready held low for 3 cycles and one idle cycle between beats. Expect mem_req_valid and mem_req_addr stable throughout, and the correct words stored.
- Flush: pulse flush in IDLE, then re-fetch 0x100 and expect a miss. Pulse flush mid-WAIT and expect the refill to complete, after which the same pcF misses again.
- Reset mid-refill: drive rst low during WAIT after 2 beats. Expect mem_req_valid=0 and all lines invalid; 0x100 misses after reset and late beats have no effect.

Source files
------------

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache between fetch and instruction memory.
// Latency: a hit returns instrF combinationally in the same cycle. The minimum miss penalty is
//          1 + 1 + WORDS_PER_LINE stalled cycles before the hit is delivered.
// Backpressure: stallC is held while a line refills. The request holds until mem_req_ready.
//               Response beats are taken whenever mem_resp_valid is high in WAIT.
// Ports: clk/rst (sync, active-low); pcF/reqF fetch lookup -> instrF/stallC; flush invalidates
//        all lines; mem_req_valid/mem_req_addr/mem_req_ready refill request;
//        mem_resp_valid/mem_resp_data burst response beats in ascending word order.
module instr_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pcF,
  input  logic                  reqF,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic                  stallC,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  localparam int WO = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - 2 - WO - IW;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);
  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [WO-1:0]         LAST_BEAT = WO'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TW-1:0]         tag_mem  [LINES];
  logic [LINES-1:0]      valid;
  logic [WO-1:0]         beat;
  logic                  flush_pending;
  logic [ADDR_WIDTH-1:0] line_addr;

  // Lookup fields of the fetch address.
  logic [WO-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  assign pc_off = pcF[2 +: WO];
  assign pc_idx = pcF[2+WO +: IW];
  assign pc_tag = pcF[ADDR_WIDTH-1 -: TW];

  // Fields of the line being refilled.
  logic [IW-1:0] rf_idx;
  logic [TW-1:0] rf_tag;
  assign rf_idx = line_addr[2+WO +: IW];
  assign rf_tag = line_addr[ADDR_WIDTH-1 -: TW];

  logic hit, miss, beat_en, last_beat;
  assign hit       = (state == IDLE) && reqF && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss      = (state == IDLE) && reqF && !hit;
  assign beat_en   = (state == WAIT) && mem_resp_valid;
  assign last_beat = beat_en && (beat == LAST_BEAT);

  // Byte offset bits never take part in a lookup or a refill address.
  logic unused_bits;
  assign unused_bits = &{1'b0, pcF[1:0], line_addr[2+WO-1:0]};

  always_comb begin
    state_nxt     = state;
    instrF        = NOP;
    stallC        = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (hit) instrF = data_mem[{pc_idx, pc_off}];
        stallC = miss;
        // A flush in the same cycle as a miss wins; the miss is retried next cycle.
        if (miss && !flush) state_nxt = REQ;
      end
      REQ: begin
        stallC        = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        stallC = 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req_addr = line_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      line_addr     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          else if (miss) line_addr <= pcF & ~LINE_MASK;
        end
        REQ: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_req_ready) beat <= '0;
        end
        WAIT: begin
          if (flush) flush_pending <= 1'b1;
          if (beat_en) beat <= beat + WO'(1);
          // The refill always completes (no cancel on the memory port). A flush seen
          // during the refill then clears every line, including the one just filled.
          if (last_beat) begin
            if (flush_pending || flush) valid <= '0;
            else valid[rf_idx] <= 1'b1;
            flush_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays hold no reset state; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rst && beat_en) begin
      data_mem[{rf_idx, beat}] <= mem_resp_data;
      if (last_beat) tag_mem[rf_idx] <= rf_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed vectors plus hand-written refill sequences for instr_cache.
module tb_instr_cache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        reqF;
  logic [31:0] instrF;
  logic        stallC;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_cache dut (
    .clk(clk), .rst(rst), .pcF(pcF), .reqF(reqF), .instrF(instrF), .stallC(stallC),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic [31:0] instr;
    logic        stall;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One lookup cycle; reqF is dropped before the edge so a miss does not start a refill.
  task automatic run_vec(input vec_t v, input int n);
    string nm;
    nm = $sformatf("vec%0d", n);
    pcF  = v.pc;
    reqF = v.req;
    @(negedge clk);
    chk({nm, ".instr"}, instrF, v.instr);
    chk({nm, ".stall"}, {31'b0, stallC}, {31'b0, v.stall});
    chk({nm, ".reqv"}, {31'b0, mem_req_valid}, 32'd0);
    reqF = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full miss/refill of the line holding pc; memory returns base+0..base+3.
  task automatic miss_refill(input string nm, input logic [31:0] pc, input logic [31:0] base,
                             input int rdy_dly, input bit gap, input int flush_beat,
                             input bit exp_hit);
    int sc;
    logic [31:0] line;
    sc   = 0;
    line = pc & ~32'hF;
    pcF  = pc;
    reqF = 1'b1;
    @(negedge clk);
    chk({nm, ".detect_stall"}, {31'b0, stallC}, 32'd1);
    if (stallC) sc++;
    @(posedge clk); #1;
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_req_ready = (i == rdy_dly);
      @(negedge clk);
      chk({nm, ".req_valid"}, {31'b0, mem_req_valid}, 32'd1);
      chk({nm, ".req_addr"}, mem_req_addr, line);
      if (stallC) sc++;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (gap && b > 0) begin
        @(negedge clk);
        if (stallC) sc++;
        @(posedge clk); #1;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 32'(b);
      flush          = (b == flush_beat);
      @(negedge clk);
      chk({nm, ".wait_reqv"}, {31'b0, mem_req_valid}, 32'd0);
      if (stallC) sc++;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      flush          = 1'b0;
    end
    chk({nm, ".stall_cycles"}, 32'(sc), 32'(6 + rdy_dly + (gap ? 3 : 0)));
    @(negedge clk);
    chk({nm, ".final_stall"}, {31'b0, stallC}, exp_hit ? 32'd0 : 32'd1);
    chk({nm, ".final_instr"}, instrF, exp_hit ? base + 32'(pc[3:2]) : NOP);
    reqF = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Segment 1: hits after the cold fill of 0x100 (0..5).
    tbl[0]  = '{32'h104, 1'b1, 32'hA1, 1'b0};
    tbl[1]  = '{32'h108, 1'b1, 32'hA2, 1'b0};
    tbl[2]  = '{32'h10C, 1'b1, 32'hA3, 1'b0};
    tbl[3]  = '{32'h107, 1'b1, 32'hA1, 1'b0};
    tbl[4]  = '{32'h100, 1'b0, NOP,    1'b0};
    tbl[5]  = '{32'h110, 1'b1, NOP,    1'b1};
    // Segment 2: after the conflicting fill of 0x200 (6..8).
    tbl[6]  = '{32'h200, 1'b1, 32'hB0, 1'b0};
    tbl[7]  = '{32'h20C, 1'b1, 32'hB3, 1'b0};
    tbl[8]  = '{32'h100, 1'b1, NOP,    1'b1};
    // Segment 3: after the backpressured refill of 0x100 (9..12).
    tbl[9]  = '{32'h104, 1'b1, 32'hA1, 1'b0};
    tbl[10] = '{32'h108, 1'b1, 32'hA2, 1'b0};
    tbl[11] = '{32'h10C, 1'b1, 32'hA3, 1'b0};
    tbl[12] = '{32'h200, 1'b1, NOP,    1'b1};
    // Segment 4: after an IDLE flush, and after a reset mid-refill (13..16).
    tbl[13] = '{32'h100, 1'b1, NOP,    1'b1};
    tbl[14] = '{32'h100, 1'b1, NOP,    1'b1};
    tbl[15] = '{32'h300, 1'b1, NOP,    1'b1};
    tbl[16] = '{32'h104, 1'b1, 32'hC1, 1'b0};

    rst = 1'b0; pcF = '0; reqF = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.reqv", {31'b0, mem_req_valid}, 32'd0);
    chk("rst.addr", mem_req_addr, 32'd0);
    chk("rst.stall", {31'b0, stallC}, 32'd0);
    chk("rst.instr", instrF, NOP);
    rst = 1'b1;
    @(posedge clk); #1;

    miss_refill("cold", 32'h100, 32'hA0, 0, 1'b0, -1, 1'b1);
    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    miss_refill("conflict", 32'h200, 32'hB0, 0, 1'b0, -1, 1'b1);
    for (int i = 6; i < 9; i++) run_vec(tbl[i], i);

    miss_refill("backpr", 32'h100, 32'hA0, 3, 1'b1, -1, 1'b1);
    for (int i = 9; i < 13; i++) run_vec(tbl[i], i);

    // Flush together with a miss: stays idle, no request next cycle.
    pcF = 32'h400; reqF = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flmiss.stall", {31'b0, stallC}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; reqF = 1'b0;
    @(negedge clk);
    chk("flmiss.noreq", {31'b0, mem_req_valid}, 32'd0);
    @(posedge clk); #1;

    // The line at 0x100 survived the flush above? No: everything was invalidated.
    run_vec(tbl[13], 13);
    miss_refill("refill1", 32'h100, 32'hA0, 0, 1'b0, -1, 1'b1);

    // Flush in IDLE: the same-cycle lookup still hits on the old valid bits.
    pcF = 32'h100; reqF = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flidle.instr", instrF, 32'hA0);
    chk("flidle.stall", {31'b0, stallC}, 32'd0);
    reqF = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    run_vec(tbl[14], 14);

    // Flush mid-WAIT: the refill completes but the line ends invalid.
    miss_refill("flwait", 32'h100, 32'hD0, 0, 1'b0, 1, 1'b0);
    miss_refill("refill2", 32'h100, 32'hE0, 0, 1'b0, -1, 1'b1);

    // Reset after two beats of a refill to 0x300.
    pcF = 32'h300; reqF = 1'b1;
    @(posedge clk); #1;
    reqF = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hF0 + 32'(b);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.reqv", {31'b0, mem_req_valid}, 32'd0);
    chk("rstmid.addr", mem_req_addr, 32'd0);
    rst = 1'b1;
    for (int b = 2; b < 4; b++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hF0 + 32'(b);
      @(negedge clk);
      chk("late.reqv", {31'b0, mem_req_valid}, 32'd0);
      chk("late.stall", {31'b0, stallC}, 32'd0);
    end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    run_vec(tbl[15], 15);
    miss_refill("afterrst", 32'h100, 32'hC0, 0, 1'b0, -1, 1'b1);
    run_vec(tbl[16], 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
